// File: rtl/rob_commit_unit.sv
// rob_commit_unit: records dispatched ROB entries, marks them done on writeback, retires up to two per cycle in program order.
// Latency: retire outputs are combinational from registered state; all state updates land on the next clk edge.
// Backpressure: none; i_stall masks dispatch only. Optional macro ROB_RETIRE_CNT_EN adds the o_retire_cnt counter port.
module rob_commit_unit #(
   parameter int ROB_ENT_NUM = 64,
   parameter int ROB_ENT_SEL = 6,
   parameter int RD_W        = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_stall,
   input  logic                   i_dp_vld_1,
   input  logic                   i_dp_vld_2,
   input  logic [ROB_ENT_SEL-1:0] i_dp_ptr_1,
   input  logic [ROB_ENT_SEL-1:0] i_dp_ptr_2,
   input  logic [RD_W-1:0]        i_dp_rd_1,
   input  logic [RD_W-1:0]        i_dp_rd_2,
   input  logic                   i_dp_rdwe_1,
   input  logic                   i_dp_rdwe_2,
   input  logic                   i_wb_vld_1,
   input  logic                   i_wb_vld_2,
   input  logic [ROB_ENT_SEL-1:0] i_wb_ptr_1,
   input  logic [ROB_ENT_SEL-1:0] i_wb_ptr_2,
   output logic [1:0]             o_com_num,
   output logic                   o_com_vld_1,
   output logic                   o_com_vld_2,
   output logic [ROB_ENT_SEL-1:0] o_com_ptr_1,
   output logic [ROB_ENT_SEL-1:0] o_com_ptr_2,
   output logic [RD_W-1:0]        o_com_rd_1,
   output logic [RD_W-1:0]        o_com_rd_2,
   output logic                   o_com_rdwe_1,
   output logic                   o_com_rdwe_2,
`ifdef ROB_RETIRE_CNT_EN
   output logic [31:0]            o_retire_cnt,
`endif
   output logic                   o_empty
);

   logic [ROB_ENT_NUM-1:0] busy_q, busy_d;
   logic [ROB_ENT_NUM-1:0] done_q, done_d;
   logic [ROB_ENT_NUM-1:0] rdwe_q;
   logic [RD_W-1:0]        rd_q [ROB_ENT_NUM];
   logic [ROB_ENT_SEL-1:0] com_ptr_q, com_ptr_d;
   logic [ROB_ENT_SEL-1:0] com_ptr_nx;
   logic                   com_vld_1, com_vld_2;
   logic [1:0]             com_num;
   logic                   dp_en_1, dp_en_2;

   assign dp_en_1 = !i_stall && i_dp_vld_1;
   assign dp_en_2 = !i_stall && i_dp_vld_2;

   // Index arithmetic is ROB_ENT_SEL bits wide, so the 63->0 wrap is free.
   assign com_ptr_nx = com_ptr_q + ROB_ENT_SEL'(1);

   // Retire is masked while reset is asserted so discarded entries never report as retired.
   assign com_vld_1 = rst_n && busy_q[com_ptr_q] && done_q[com_ptr_q];
   assign com_vld_2 = com_vld_1 && busy_q[com_ptr_nx] && done_q[com_ptr_nx];
   assign com_num   = {1'b0, com_vld_1} + {1'b0, com_vld_2};

   assign o_com_num    = com_num;
   assign o_com_vld_1  = com_vld_1;
   assign o_com_vld_2  = com_vld_2;
   assign o_com_ptr_1  = com_ptr_q;
   assign o_com_ptr_2  = com_ptr_nx;
   assign o_com_rd_1   = rd_q[com_ptr_q];
   assign o_com_rd_2   = rd_q[com_ptr_nx];
   assign o_com_rdwe_1 = rdwe_q[com_ptr_q] & com_vld_1;
   assign o_com_rdwe_2 = rdwe_q[com_ptr_nx] & com_vld_2;
   assign o_empty      = ~|busy_q;

   // Next-state for busy/done: writeback, then retire clear, then dispatch set (dispatch wins on reuse).
   always_comb begin
      busy_d    = busy_q;
      done_d    = done_q;
      com_ptr_d = com_ptr_q + ROB_ENT_SEL'(com_num);
      if (i_wb_vld_1 && busy_q[i_wb_ptr_1]) begin
         done_d[i_wb_ptr_1] = 1'b1;
      end
      if (i_wb_vld_2 && busy_q[i_wb_ptr_2]) begin
         done_d[i_wb_ptr_2] = 1'b1;
      end
      if (com_vld_1) begin
         busy_d[com_ptr_q] = 1'b0;
         done_d[com_ptr_q] = 1'b0;
      end
      if (com_vld_2) begin
         busy_d[com_ptr_nx] = 1'b0;
         done_d[com_ptr_nx] = 1'b0;
      end
      if (dp_en_1) begin
         busy_d[i_dp_ptr_1] = 1'b1;
         done_d[i_dp_ptr_1] = 1'b0;
      end
      if (dp_en_2) begin
         busy_d[i_dp_ptr_2] = 1'b1;
         done_d[i_dp_ptr_2] = 1'b0;
      end
   end

   // Entry status and commit pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q    <= '0;
         done_q    <= '0;
         com_ptr_q <= '0;
      end else begin
         busy_q    <= busy_d;
         done_q    <= done_d;
         com_ptr_q <= com_ptr_d;
      end
   end

   // Entry payload; only meaningful while busy, so it needs no reset.
   always_ff @(posedge clk) begin
      if (dp_en_1) begin
         rd_q[i_dp_ptr_1]   <= i_dp_rd_1;
         rdwe_q[i_dp_ptr_1] <= i_dp_rdwe_1;
      end
      if (dp_en_2) begin
         rd_q[i_dp_ptr_2]   <= i_dp_rd_2;
         rdwe_q[i_dp_ptr_2] <= i_dp_rdwe_2;
      end
   end

`ifdef ROB_RETIRE_CNT_EN
   logic [31:0] retire_cnt_q;

   // Running total of retired entries, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retire_cnt_q <= '0;
      end else begin
         retire_cnt_q <= retire_cnt_q + 32'(com_num);
      end
   end

   assign o_retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: scenario tasks with inline checks plus an in-order retire scoreboard.
module tb_rob_commit_unit;
   localparam int N   = 64;
   localparam int SEL = 6;
   localparam int RW  = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           i_stall, i_dp_vld_1, i_dp_vld_2;
   logic [SEL-1:0] i_dp_ptr_1, i_dp_ptr_2;
   logic [RW-1:0]  i_dp_rd_1, i_dp_rd_2;
   logic           i_dp_rdwe_1, i_dp_rdwe_2;
   logic           i_wb_vld_1, i_wb_vld_2;
   logic [SEL-1:0] i_wb_ptr_1, i_wb_ptr_2;
   logic [1:0]     o_com_num;
   logic           o_com_vld_1, o_com_vld_2;
   logic [SEL-1:0] o_com_ptr_1, o_com_ptr_2;
   logic [RW-1:0]  o_com_rd_1, o_com_rd_2;
   logic           o_com_rdwe_1, o_com_rdwe_2;
   logic           o_empty;
`ifdef ROB_RETIRE_CNT_EN
   logic [31:0]    o_retire_cnt;
`endif

   typedef struct packed {
      logic [SEL-1:0] ptr;
      logic [RW-1:0]  rd;
      logic           rdwe;
   } exp_t;

   exp_t sb[$];
   int   chk_cnt   = 0;
   int   pass_cnt  = 0;
   int   ret_total = 0;

   always #5 clk = ~clk;

   rob_commit_unit #(.ROB_ENT_NUM(N), .ROB_ENT_SEL(SEL), .RD_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .i_stall(i_stall),
      .i_dp_vld_1(i_dp_vld_1), .i_dp_vld_2(i_dp_vld_2),
      .i_dp_ptr_1(i_dp_ptr_1), .i_dp_ptr_2(i_dp_ptr_2),
      .i_dp_rd_1(i_dp_rd_1), .i_dp_rd_2(i_dp_rd_2),
      .i_dp_rdwe_1(i_dp_rdwe_1), .i_dp_rdwe_2(i_dp_rdwe_2),
      .i_wb_vld_1(i_wb_vld_1), .i_wb_vld_2(i_wb_vld_2),
      .i_wb_ptr_1(i_wb_ptr_1), .i_wb_ptr_2(i_wb_ptr_2),
      .o_com_num(o_com_num), .o_com_vld_1(o_com_vld_1), .o_com_vld_2(o_com_vld_2),
      .o_com_ptr_1(o_com_ptr_1), .o_com_ptr_2(o_com_ptr_2),
      .o_com_rd_1(o_com_rd_1), .o_com_rd_2(o_com_rd_2),
      .o_com_rdwe_1(o_com_rdwe_1), .o_com_rdwe_2(o_com_rdwe_2),
`ifdef ROB_RETIRE_CNT_EN
      .o_retire_cnt(o_retire_cnt),
`endif
      .o_empty(o_empty)
   );

   // Scoreboard: every reported retire must match the oldest outstanding dispatch.
   always @(negedge clk) begin
      exp_t e;
      ret_total = ret_total + int'(o_com_num);
      if (o_com_vld_1 === 1'b1) begin
         chk_cnt++;
         if (sb.size() == 0) begin
            $display("FAIL sb_slot1: unexpected retire ptr=%0d, expected none", o_com_ptr_1);
         end else begin
            e = sb.pop_front();
            if ({o_com_ptr_1, o_com_rd_1, o_com_rdwe_1} !== e)
               $display("FAIL sb_slot1: got ptr=%0d rd=%0d rdwe=%0b, expected ptr=%0d rd=%0d rdwe=%0b",
                        o_com_ptr_1, o_com_rd_1, o_com_rdwe_1, e.ptr, e.rd, e.rdwe);
            else pass_cnt++;
         end
      end
      if (o_com_vld_2 === 1'b1) begin
         chk_cnt++;
         if (sb.size() == 0) begin
            $display("FAIL sb_slot2: unexpected retire ptr=%0d, expected none", o_com_ptr_2);
         end else begin
            e = sb.pop_front();
            if ({o_com_ptr_2, o_com_rd_2, o_com_rdwe_2} !== e)
               $display("FAIL sb_slot2: got ptr=%0d rd=%0d rdwe=%0b, expected ptr=%0d rd=%0d rdwe=%0b",
                        o_com_ptr_2, o_com_rd_2, o_com_rdwe_2, e.ptr, e.rd, e.rdwe);
            else pass_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      i_stall = 1'b0;
      i_dp_vld_1 = 1'b0; i_dp_vld_2 = 1'b0;
      i_dp_ptr_1 = '0;   i_dp_ptr_2 = '0;
      i_dp_rd_1 = '0;    i_dp_rd_2 = '0;
      i_dp_rdwe_1 = 1'b0; i_dp_rdwe_2 = 1'b0;
      i_wb_vld_1 = 1'b0; i_wb_vld_2 = 1'b0;
      i_wb_ptr_1 = '0;   i_wb_ptr_2 = '0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_in();
      sb.delete();
      ret_total = 0;
      tick();
      rst_n = 1'b1;
   endtask

   // Drives one dispatch cycle and records the expected retire order.
   task automatic drive_dp(input logic two, input logic [SEL-1:0] p,
                           input logic [RW-1:0] r1, input logic w1,
                           input logic [RW-1:0] r2, input logic w2);
      logic [SEL-1:0] p2;
      p2 = p + SEL'(1);
      i_dp_vld_1 = 1'b1; i_dp_vld_2 = two;
      i_dp_ptr_1 = p;    i_dp_ptr_2 = p2;
      i_dp_rd_1 = r1;    i_dp_rd_2 = r2;
      i_dp_rdwe_1 = w1;  i_dp_rdwe_2 = w2;
      sb.push_back('{ptr: p, rd: r1, rdwe: w1});
      if (two) sb.push_back('{ptr: p2, rd: r2, rdwe: w2});
   endtask

   task automatic drive_wb(input logic v1, input logic [SEL-1:0] p1,
                           input logic v2, input logic [SEL-1:0] p2);
      i_wb_vld_1 = v1; i_wb_ptr_1 = p1;
      i_wb_vld_2 = v2; i_wb_ptr_2 = p2;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_cnt++;
         if ({o_com_num, o_com_vld_1, o_com_vld_2, o_empty} !== 5'b00001)
            $display("FAIL reset_idle: num=%0d vld1=%0b vld2=%0b empty=%0b, expected 0/0/0/1",
                     o_com_num, o_com_vld_1, o_com_vld_2, o_empty);
         else pass_cnt++;
      end
`ifdef ROB_RETIRE_CNT_EN
      chk_cnt++;
      if (o_retire_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d expected 0", o_retire_cnt);
      else pass_cnt++;
`endif
   endtask

   task automatic test_pair_retire();
      apply_reset();
      drive_dp(1'b1, 6'd0, 5'd3, 1'b1, 5'd4, 1'b1); tick(); idle_in();
      chk_cnt++;
      if (o_com_num !== 2'd0 || o_empty !== 1'b0)
         $display("FAIL pair_dispatched: num=%0d empty=%0b, expected 0/0", o_com_num, o_empty);
      else pass_cnt++;
      drive_wb(1'b1, 6'd1, 1'b0, 6'd0); tick(); idle_in();
      chk_cnt++;
      if (o_com_num !== 2'd0) $display("FAIL pair_only_e1: num=%0d expected 0", o_com_num);
      else pass_cnt++;
      drive_wb(1'b1, 6'd0, 1'b0, 6'd0); tick(); idle_in();
      chk_cnt++;
      if (o_com_num !== 2'd2 || o_com_ptr_1 !== 6'd0 || o_com_ptr_2 !== 6'd1 ||
          o_com_rd_1 !== 5'd3 || o_com_rd_2 !== 5'd4)
         $display("FAIL pair_retire: num=%0d ptr=%0d/%0d rd=%0d/%0d, expected 2 ptr=0/1 rd=3/4",
                  o_com_num, o_com_ptr_1, o_com_ptr_2, o_com_rd_1, o_com_rd_2);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (o_empty !== 1'b1 || o_com_num !== 2'd0)
         $display("FAIL pair_empty: empty=%0b num=%0d, expected 1/0", o_empty, o_com_num);
      else pass_cnt++;
`ifdef ROB_RETIRE_CNT_EN
      chk_cnt++;
      if (o_retire_cnt !== 32'(ret_total))
         $display("FAIL pair_cnt: got %0d expected %0d", o_retire_cnt, ret_total);
      else pass_cnt++;
`endif
   endtask

   task automatic test_out_of_order();
      apply_reset();
      drive_dp(1'b1, 6'd0, 5'd7, 1'b1, 5'd8, 1'b0); tick(); idle_in();
      drive_dp(1'b0, 6'd2, 5'd9, 1'b1, 5'd0, 1'b0); tick(); idle_in();
      drive_wb(1'b1, 6'd0, 1'b1, 6'd2); tick(); idle_in();
      chk_cnt++;
      if (o_com_num !== 2'd1 || o_com_ptr_1 !== 6'd0)
         $display("FAIL ooo_first: num=%0d ptr=%0d, expected 1 ptr=0", o_com_num, o_com_ptr_1);
      else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_cnt++;
         if (o_com_num !== 2'd0) $display("FAIL ooo_hold: num=%0d expected 0", o_com_num);
         else pass_cnt++;
      end
      drive_wb(1'b1, 6'd1, 1'b0, 6'd0); tick(); idle_in();
      chk_cnt++;
      if (o_com_num !== 2'd2 || o_com_ptr_1 !== 6'd1 || o_com_ptr_2 !== 6'd2 || o_com_rdwe_1 !== 1'b0)
         $display("FAIL ooo_pair: num=%0d ptr=%0d/%0d rdwe1=%0b, expected 2 ptr=1/2 rdwe1=0",
                  o_com_num, o_com_ptr_1, o_com_ptr_2, o_com_rdwe_1);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (o_empty !== 1'b1) $display("FAIL ooo_empty: empty=%0b expected 1", o_empty);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 63; i++) begin
         drive_dp(1'b0, SEL'(i), RW'(i), 1'b1, 5'd0, 1'b0); tick(); idle_in();
         drive_wb(1'b1, SEL'(i), 1'b0, 6'd0); tick(); idle_in();
         chk_cnt++;
         if (o_com_num !== 2'd1 || o_com_ptr_1 !== SEL'(i))
            $display("FAIL wrap_advance: num=%0d ptr=%0d, expected 1 ptr=%0d", o_com_num, o_com_ptr_1, i);
         else pass_cnt++;
         tick();
      end
      drive_dp(1'b1, 6'd63, 5'd11, 1'b1, 5'd12, 1'b1); tick(); idle_in();
      drive_wb(1'b1, 6'd63, 1'b1, 6'd0); tick(); idle_in();
      chk_cnt++;
      if (o_com_num !== 2'd2 || o_com_ptr_1 !== 6'd63 || o_com_ptr_2 !== 6'd0)
         $display("FAIL wrap_pair: num=%0d ptr=%0d/%0d, expected 2 ptr=63/0",
                  o_com_num, o_com_ptr_1, o_com_ptr_2);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (o_com_ptr_1 !== 6'd1 || o_empty !== 1'b1)
         $display("FAIL wrap_ptr_after: ptr=%0d empty=%0b, expected 1/1", o_com_ptr_1, o_empty);
      else pass_cnt++;
   endtask

   task automatic test_full_redispatch();
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         drive_dp(1'b1, SEL'(2 * i), RW'(2 * i), 1'b1, RW'(2 * i + 1), 1'b1); tick(); idle_in();
      end
      chk_cnt++;
      if (o_com_num !== 2'd0 || o_empty !== 1'b0)
         $display("FAIL full_idle: num=%0d empty=%0b, expected 0/0", o_com_num, o_empty);
      else pass_cnt++;
      drive_wb(1'b1, 6'd0, 1'b0, 6'd0); tick(); idle_in();
      chk_cnt++;
      if (o_com_num !== 2'd1 || o_com_ptr_1 !== 6'd0 || o_com_rd_1 !== 5'd0)
         $display("FAIL full_retire: num=%0d ptr=%0d rd=%0d, expected 1 ptr=0 rd=0",
                  o_com_num, o_com_ptr_1, o_com_rd_1);
      else pass_cnt++;
      drive_dp(1'b0, 6'd0, 5'd17, 1'b1, 5'd0, 1'b0); tick(); idle_in();
      chk_cnt++;
      if (o_com_num !== 2'd0 || o_empty !== 1'b0)
         $display("FAIL full_redisp_hold: num=%0d empty=%0b, expected 0/0", o_com_num, o_empty);
      else pass_cnt++;
      for (int k = 1; k < 63; k += 2) begin
         drive_wb(1'b1, SEL'(k), 1'b1, SEL'(k + 1)); tick(); idle_in();
      end
      drive_wb(1'b1, 6'd63, 1'b0, 6'd0); tick(); idle_in();
      tick(); tick();
      chk_cnt++;
      if (o_com_num !== 2'd0 || o_empty !== 1'b0 || o_com_ptr_1 !== 6'd0)
         $display("FAIL full_new_not_done: num=%0d empty=%0b ptr=%0d, expected 0/0 ptr=0",
                  o_com_num, o_empty, o_com_ptr_1);
      else pass_cnt++;
      drive_wb(1'b1, 6'd0, 1'b0, 6'd0); tick(); idle_in();
      chk_cnt++;
      if (o_com_num !== 2'd1 || o_com_rd_1 !== 5'd17)
         $display("FAIL full_new_retire: num=%0d rd=%0d, expected 1 rd=17", o_com_num, o_com_rd_1);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (o_empty !== 1'b1 || sb.size() != 0)
         $display("FAIL full_drained: empty=%0b outstanding=%0d, expected 1/0", o_empty, sb.size());
      else pass_cnt++;
`ifdef ROB_RETIRE_CNT_EN
      chk_cnt++;
      if (o_retire_cnt !== 32'(ret_total))
         $display("FAIL full_cnt: got %0d expected %0d", o_retire_cnt, ret_total);
      else pass_cnt++;
`endif
   endtask

   task automatic test_stall_nonbusy();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         drive_dp(1'b1, SEL'(2 * i), 5'd1, 1'b1, 5'd2, 1'b0); tick(); idle_in();
         drive_wb(1'b1, SEL'(2 * i), 1'b1, SEL'(2 * i + 1)); tick(); idle_in();
         tick();
      end
      i_stall = 1'b1; i_dp_vld_1 = 1'b1; i_dp_ptr_1 = 6'd10; i_dp_rd_1 = 5'd5; i_dp_rdwe_1 = 1'b1;
      drive_wb(1'b1, 6'd10, 1'b0, 6'd0); tick(); idle_in();
      chk_cnt++;
      if (o_empty !== 1'b1 || o_com_num !== 2'd0 || o_com_ptr_1 !== 6'd10)
         $display("FAIL stall_nonbusy: empty=%0b num=%0d ptr=%0d, expected 1/0 ptr=10",
                  o_empty, o_com_num, o_com_ptr_1);
      else pass_cnt++;
      drive_wb(1'b1, 6'd10, 1'b1, 6'd11); tick(); idle_in();
      drive_dp(1'b0, 6'd10, 5'd6, 1'b1, 5'd0, 1'b0); tick(); idle_in();
      chk_cnt++;
      if (o_com_num !== 2'd0 || o_empty !== 1'b0)
         $display("FAIL nonbusy_wb_ignored: num=%0d empty=%0b, expected 0/0", o_com_num, o_empty);
      else pass_cnt++;
      drive_wb(1'b1, 6'd10, 1'b0, 6'd0); tick(); idle_in();
      i_stall = 1'b1;
      #1;
      chk_cnt++;
      if (o_com_num !== 2'd1 || o_com_rd_1 !== 5'd6)
         $display("FAIL retire_under_stall: num=%0d rd=%0d, expected 1 rd=6", o_com_num, o_com_rd_1);
      else pass_cnt++;
      tick(); idle_in();
      chk_cnt++;
      if (o_empty !== 1'b1) $display("FAIL stall_empty: empty=%0b expected 1", o_empty);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      apply_reset();
      drive_dp(1'b1, 6'd0, 5'd1, 1'b1, 5'd2, 1'b1); tick(); idle_in();
      drive_wb(1'b1, 6'd0, 1'b1, 6'd1); tick(); idle_in();
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({o_com_num, o_com_vld_1, o_com_vld_2} !== 4'b0000)
         $display("FAIL midrst_during: num=%0d vld=%0b/%0b, expected 0/0/0",
                  o_com_num, o_com_vld_1, o_com_vld_2);
      else pass_cnt++;
      sb.delete();
      ret_total = 0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk_cnt++;
         if (o_empty !== 1'b1 || o_com_num !== 2'd0)
            $display("FAIL midrst_after: empty=%0b num=%0d, expected 1/0", o_empty, o_com_num);
         else pass_cnt++;
         tick();
      end
`ifdef ROB_RETIRE_CNT_EN
      chk_cnt++;
      if (o_retire_cnt !== 32'd0) $display("FAIL midrst_cnt: got %0d expected 0", o_retire_cnt);
      else pass_cnt++;
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      idle_in();
      test_reset();
      test_pair_retire();
      test_out_of_order();
      test_wrap();
      test_full_redispatch();
      test_stall_nonbusy();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
